// File: rtl/cga_vram_sequencer.sv
// CGA character-clock sequencer: phase counter, display fetch strobes, CRTC clock
// enable, and a VRAM arbiter that gives CPU accesses every cycle not used by a display slot.
module cga_vram_sequencer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hres_mode,
  input  logic        grph_mode,
  input  logic [12:0] disp_addr,
  input  logic [4:0]  row_addr,
  input  logic [7:0]  vram_data,
  output logic [4:0]  clk_seq,
  output logic        crtc_clk,
  output logic        vram_read_char,
  output logic        vram_read_att,
  output logic        charrom_read,
  output logic        disp_pipeline,
  output logic [13:0] vram_addr,
  output logic        vram_we,
  output logic [7:0]  vram_wdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_wait
);

  typedef enum logic [1:0] {
    CPU_IDLE,
    CPU_DATA,
    CPU_RELEASE
  } cpu_state_t;

  cpu_state_t  state;
  cpu_state_t  state_next;
  logic        hres_eff;
  logic        hres_next;
  logic [4:0]  seq_next;
  logic [4:0]  ph_next;
  logic        disp_slot;
  logic [13:0] disp_vaddr;
  logic        cpu_issue;
  logic        cpu_capture;

  // Every registered output is decoded from the phase of the cycle it will be
  // visible in, so the counter value and its strobes line up on the same clk.
  always_comb begin
    seq_next   = clk_seq + 5'd1;
    hres_next  = (clk_seq == 5'd31) ? hres_mode : hres_eff;
    ph_next    = hres_next ? {1'b0, seq_next[3:0]} : seq_next;
    disp_slot  = (ph_next == 5'd0) || (ph_next == 5'd1);
    disp_vaddr = grph_mode ? {row_addr[0], disp_addr[11:0], ph_next[0]}
                           : {disp_addr, ph_next[0]};
  end

  // NOTE: every signal written in always_comb gets a default first, so no path
  // through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next  = state;
    cpu_issue   = 1'b0;
    cpu_capture = 1'b0;
    case (state)
      CPU_IDLE: begin
        if (cpu_req && !disp_slot) begin
          cpu_issue  = 1'b1;
          state_next = CPU_DATA;
        end
      end
      CPU_DATA: begin
        cpu_capture = 1'b1;
        state_next  = CPU_RELEASE;
      end
      CPU_RELEASE: begin
        if (!cpu_req) state_next = CPU_IDLE;
      end
      default: state_next = CPU_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= CPU_IDLE;
      clk_seq        <= 5'd0;
      hres_eff       <= 1'b0;
      crtc_clk       <= 1'b0;
      vram_read_char <= 1'b0;
      vram_read_att  <= 1'b0;
      charrom_read   <= 1'b0;
      disp_pipeline  <= 1'b0;
      vram_addr      <= 14'd0;
      vram_we        <= 1'b0;
      vram_wdata     <= 8'd0;
      cpu_rdata      <= 8'd0;
      cpu_ack        <= 1'b0;
    end else begin
      state          <= state_next;
      clk_seq        <= seq_next;
      hres_eff       <= hres_next;
      vram_read_char <= (ph_next == 5'd1);
      vram_read_att  <= (ph_next == 5'd2);
      charrom_read   <= (ph_next == 5'd3);
      disp_pipeline  <= (ph_next == 5'd3);
      crtc_clk       <= (ph_next[3:0] == 4'hF) && (hres_next || ph_next[4]);
      vram_we        <= cpu_issue && cpu_we;
      cpu_ack        <= cpu_capture;

      if (disp_slot) begin
        vram_addr <= disp_vaddr;
      end else if (cpu_issue) begin
        vram_addr  <= cpu_addr;
        vram_wdata <= cpu_wdata;
      end

      // vram_we is still high during the data cycle of a write, so reads alone update rdata.
      if (cpu_capture && !vram_we) cpu_rdata <= vram_data;
    end
  end

  assign cpu_wait = cpu_req & ~cpu_ack;

endmodule

// File: tb/tb_cga_vram_sequencer.sv
// Directed bench for cga_vram_sequencer: table of display-slot vectors plus
// hand-written CPU arbitration, mode-switch and reset sequences.
module tb_cga_vram_sequencer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hres_mode;
  logic        grph_mode;
  logic [12:0] disp_addr;
  logic [4:0]  row_addr;
  logic [7:0]  vram_data;
  logic [4:0]  clk_seq;
  logic        crtc_clk;
  logic        vram_read_char;
  logic        vram_read_att;
  logic        charrom_read;
  logic        disp_pipeline;
  logic [13:0] vram_addr;
  logic        vram_we;
  logic [7:0]  vram_wdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic [7:0]  cpu_rdata;
  logic        cpu_ack;
  logic        cpu_wait;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cga_vram_sequencer dut (
    .clk(clk), .reset_n(reset_n), .hres_mode(hres_mode), .grph_mode(grph_mode),
    .disp_addr(disp_addr), .row_addr(row_addr), .vram_data(vram_data),
    .clk_seq(clk_seq), .crtc_clk(crtc_clk), .vram_read_char(vram_read_char),
    .vram_read_att(vram_read_att), .charrom_read(charrom_read),
    .disp_pipeline(disp_pipeline), .vram_addr(vram_addr), .vram_we(vram_we),
    .vram_wdata(vram_wdata), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_wait(cpu_wait)
  );

  // strb packs {vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk}
  typedef struct {
    logic        hres;
    logic        grph;
    logic [12:0] daddr;
    logic [4:0]  raddr;
    logic [4:0]  seq;
    logic [13:0] addr;
    logic [4:0]  strb;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Advances at least one cycle, then stops at the negedge where clk_seq == target.
  task automatic wait_seq(input logic [4:0] target);
    bit found = 0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (clk_seq == target) found = 1;
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL wait_seq timeout: clk_seq never reached %0d", target);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {vram_read_char, vram_read_att, charrom_read, disp_pipeline, crtc_clk};
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 13'h0123, 5'd0, 5'd0,  14'h0246, 5'b00000};
    vecs[1]  = '{1'b1, 1'b0, 13'h0123, 5'd0, 5'd1,  14'h0247, 5'b10000};
    vecs[2]  = '{1'b1, 1'b0, 13'h0123, 5'd0, 5'd2,  14'h0247, 5'b01000};
    vecs[3]  = '{1'b1, 1'b0, 13'h0123, 5'd0, 5'd3,  14'h0247, 5'b00110};
    vecs[4]  = '{1'b1, 1'b0, 13'h0123, 5'd0, 5'd15, 14'h0247, 5'b00001};
    vecs[5]  = '{1'b1, 1'b0, 13'h0123, 5'd0, 5'd16, 14'h0246, 5'b00000};
    vecs[6]  = '{1'b1, 1'b0, 13'h0123, 5'd0, 5'd17, 14'h0247, 5'b10000};
    vecs[7]  = '{1'b1, 1'b0, 13'h0123, 5'd0, 5'd18, 14'h0247, 5'b01000};
    vecs[8]  = '{1'b1, 1'b0, 13'h0123, 5'd0, 5'd31, 14'h0247, 5'b00001};
    vecs[9]  = '{1'b0, 1'b1, 13'h0010, 5'd1, 5'd0,  14'h2020, 5'b00000};
    vecs[10] = '{1'b0, 1'b1, 13'h0010, 5'd1, 5'd1,  14'h2021, 5'b10000};
    vecs[11] = '{1'b0, 1'b1, 13'h0010, 5'd1, 5'd3,  14'h2021, 5'b00110};
    vecs[12] = '{1'b0, 1'b1, 13'h0010, 5'd1, 5'd15, 14'h2021, 5'b00000};
    vecs[13] = '{1'b0, 1'b1, 13'h0010, 5'd1, 5'd17, 14'h2021, 5'b00000};
    vecs[14] = '{1'b0, 1'b1, 13'h0010, 5'd1, 5'd31, 14'h2021, 5'b00001};
    vecs[15] = '{1'b0, 1'b0, 13'h1FFF, 5'd0, 5'd0,  14'h3FFE, 5'b00000};
    vecs[16] = '{1'b0, 1'b0, 13'h1FFF, 5'd0, 5'd1,  14'h3FFF, 5'b10000};
    vecs[17] = '{1'b0, 1'b1, 13'h1FFF, 5'd2, 5'd1,  14'h1FFF, 5'b10000};

    reset_n   = 1'b0;
    hres_mode = 1'b0;
    grph_mode = 1'b0;
    disp_addr = 13'd0;
    row_addr  = 5'd0;
    vram_data = 8'h00;
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 14'd0;
    cpu_wdata = 8'd0;

    // Reset held with a pending request
    repeat (3) @(negedge clk);
    check("rst clk_seq", clk_seq, 0);
    check("rst strobes", strobes(), 0);
    check("rst vram_addr", vram_addr, 0);
    check("rst vram_we", vram_we, 0);
    check("rst vram_wdata", vram_wdata, 0);
    check("rst cpu_rdata", cpu_rdata, 0);
    check("rst cpu_ack", cpu_ack, 0);
    check("rst cpu_wait", cpu_wait, 1);
    cpu_req = 1'b0;
    reset_n = 1'b1;
    check("rel seq0", clk_seq, 0);
    @(negedge clk);
    check("rel seq1", clk_seq, 1);
    @(negedge clk);
    check("rel seq2", clk_seq, 2);

    // Display slot vectors; each takes effect from the next wrap
    for (int i = 0; i < 18; i++) begin
      hres_mode = vecs[i].hres;
      grph_mode = vecs[i].grph;
      disp_addr = vecs[i].daddr;
      row_addr  = vecs[i].raddr;
      wait_seq(5'd31);
      wait_seq(vecs[i].seq);
      check($sformatf("vec%0d vram_addr", i), vram_addr, vecs[i].addr);
      check($sformatf("vec%0d strobes", i), strobes(), vecs[i].strb);
      check($sformatf("vec%0d vram_we", i), vram_we, 0);
    end

    // CPU read, lowres graphics display at 0x2020/0x2021
    hres_mode = 1'b0;
    grph_mode = 1'b1;
    row_addr  = 5'd1;
    disp_addr = 13'h0010;
    wait_seq(5'd31);
    wait_seq(5'd4);
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 14'h1ABC;
    vram_data = 8'h5A;
    wait_seq(5'd5);
    check("rd issue addr", vram_addr, 14'h1ABC);
    check("rd issue we", vram_we, 0);
    check("rd issue ack", cpu_ack, 0);
    check("rd issue wait", cpu_wait, 1);
    wait_seq(5'd6);
    check("rd ack", cpu_ack, 1);
    check("rd rdata", cpu_rdata, 8'h5A);
    check("rd wait low", cpu_wait, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("rd held no ack", cpu_ack, 0);
      check("rd held no reissue", vram_addr, 14'h1ABC);
    end
    cpu_req = 1'b0;

    // CPU write colliding with the display slots
    wait_seq(5'd31);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 14'h0555;
    cpu_wdata = 8'hC3;
    vram_data = 8'h77;
    wait_seq(5'd0);
    check("wr ph0 addr", vram_addr, 14'h2020);
    check("wr ph0 we", vram_we, 0);
    wait_seq(5'd1);
    check("wr ph1 addr", vram_addr, 14'h2021);
    check("wr ph1 we", vram_we, 0);
    wait_seq(5'd2);
    check("wr ph2 addr", vram_addr, 14'h0555);
    check("wr ph2 we", vram_we, 1);
    check("wr ph2 wdata", vram_wdata, 8'hC3);
    check("wr ph2 ack", cpu_ack, 0);
    wait_seq(5'd3);
    check("wr ph3 ack", cpu_ack, 1);
    check("wr ph3 we", vram_we, 0);
    check("wr rdata kept", cpu_rdata, 8'h5A);
    cpu_req = 1'b0;
    wait_seq(5'd4);
    check("wr ph4 ack", cpu_ack, 0);

    // Hres: request arriving at the second character's slot stalls to ph 2
    hres_mode = 1'b1;
    wait_seq(5'd31);
    wait_seq(5'd15);
    cpu_req   = 1'b1;
    cpu_we    = 1'b0;
    cpu_addr  = 14'h3001;
    vram_data = 8'hA5;
    wait_seq(5'd16);
    check("hr ph0 addr", vram_addr, 14'h2020);
    check("hr ph0 ack", cpu_ack, 0);
    wait_seq(5'd17);
    check("hr ph1 addr", vram_addr, 14'h2021);
    check("hr ph1 strobes", strobes(), 5'b10000);
    wait_seq(5'd18);
    check("hr ph2 addr", vram_addr, 14'h3001);
    check("hr ph2 ack", cpu_ack, 0);
    wait_seq(5'd19);
    check("hr ph3 ack", cpu_ack, 1);
    check("hr ph3 rdata", cpu_rdata, 8'hA5);
    check("hr ph3 strobes", strobes(), 5'b00110);
    cpu_req = 1'b0;

    // Mode switch mid-period: lowres pattern holds until the wrap
    hres_mode = 1'b0;
    wait_seq(5'd31);
    wait_seq(5'd9);
    hres_mode = 1'b1;
    wait_seq(5'd15);
    check("sw lowres 15", strobes(), 5'b00000);
    wait_seq(5'd17);
    check("sw lowres 17", strobes(), 5'b00000);
    wait_seq(5'd31);
    check("sw lowres 31", strobes(), 5'b00001);
    wait_seq(5'd15);
    check("sw hres 15", strobes(), 5'b00001);
    wait_seq(5'd17);
    check("sw hres 17", strobes(), 5'b10000);

    // Reset in the middle of a CPU write abandons it
    wait_seq(5'd4);
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 14'h0100;
    cpu_wdata = 8'h3C;
    wait_seq(5'd5);
    check("ab issue we", vram_we, 1);
    reset_n = 1'b0;
    #1;
    check("ab we cleared", vram_we, 0);
    check("ab addr cleared", vram_addr, 0);
    check("ab wdata cleared", vram_wdata, 0);
    @(negedge clk);
    check("ab no ack", cpu_ack, 0);
    check("ab wait", cpu_wait, 1);
    cpu_req = 1'b0;
    reset_n = 1'b1;
    check("ab seq0", clk_seq, 0);
    @(negedge clk);
    check("ab seq1", clk_seq, 1);
    check("ab seq1 ack", cpu_ack, 0);
    @(negedge clk);
    check("ab seq2", clk_seq, 2);
    check("ab seq2 ack", cpu_ack, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
